ram_wb_arb: RTL and testbench

- Parametrised N-master round-robin Wishbone B3 arbiter that drives one slave port, normally a ram_wb_b3 instance.
- Next generation of the fixed 3-master RAM front end:
  - master count, data width and address width are generic;
  - grant handover has no dead cycles;
  - access is fair under continuous contention;
  - an optional watchdog frees the bus from a stalled slave.
- Sits between CPU/debug/DMA masters and the shared on-chip RAM.

---
 rtl/ram_wb_arb_pkg.sv | 19 +
 rtl/ram_wb_arb_rr_pick.sv | 32 +++
 rtl/ram_wb_arb.sv | 158 +++++++++++++++
 tb/tb_ram_wb_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_wb_arb_pkg.sv
// Shared Wishbone B3 constants and arbiter state type for the RAM front end.
package ram_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_e;

endpackage

// File: rtl/ram_wb_arb_rr_pick.sv
// Combinational round-robin picker: one-hot winner is the first requester
// at or above ptr, wrapping to index 0.
module rr_pick #(
  parameter int nm = 3,
  parameter int pw = (nm > 1) ? $clog2(nm) : 1
) (
  input  logic [nm-1:0] req,
  input  logic [pw-1:0] ptr,
  output logic [nm-1:0] gnt
);

  logic found;

  // Upper pass covers ptr..nm-1, the lower pass supplies the wrap-around.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int j = 0; j < nm; j++) begin
      if (!found && (j >= int'(ptr)) && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int j = 0; j < nm; j++) begin
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_wb_arb.sv
// N-master round-robin Wishbone B3 arbiter in front of one slave port.
// Optional stalled-slave watchdog: define RAM_WB_ARB_WATCHDOG_EN.
module ram_wb_arb #(
  parameter int nm        = 3,
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int wd_cycles = 256
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [nm*aw-1:0]     wbm_adr_i,
  input  logic [nm*dw-1:0]     wbm_dat_i,
  input  logic [nm*dw/8-1:0]   wbm_sel_i,
  input  logic [nm*3-1:0]      wbm_cti_i,
  input  logic [nm*2-1:0]      wbm_bte_i,
  input  logic [nm-1:0]        wbm_cyc_i,
  input  logic [nm-1:0]        wbm_stb_i,
  input  logic [nm-1:0]        wbm_we_i,
  output logic [nm*dw-1:0]     wbm_dat_o,
  output logic [nm-1:0]        wbm_ack_o,
  output logic [nm-1:0]        wbm_err_o,
  output logic [nm-1:0]        wbm_rty_o,
  output logic [aw-1:0]        wbs_adr_o,
  output logic [dw-1:0]        wbs_dat_o,
  output logic [dw/8-1:0]      wbs_sel_o,
  output logic [2:0]           wbs_cti_o,
  output logic [1:0]           wbs_bte_o,
  output logic                 wbs_cyc_o,
  output logic                 wbs_stb_o,
  output logic                 wbs_we_o,
  input  logic [dw-1:0]        wbs_dat_i,
  input  logic                 wbs_ack_i,
  input  logic                 wbs_err_i,
  input  logic                 wbs_rty_i,
  output logic [nm-1:0]        grant_o
);

  import ram_wb_pkg::*;

  localparam int pw = (nm > 1) ? $clog2(nm) : 1;
  localparam int sw = dw / 8;

  arb_state_e    state;
  logic [nm-1:0] grant;
  logic [nm-1:0] pick;
  logic [pw-1:0] ptr;
  logic [pw-1:0] owner_idx;
  logic [pw-1:0] owner_inc;
  logic [pw-1:0] pick_ptr;
  logic          owner_cyc;
  logic          wd_fire;
  logic          wd_block;

  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < nm; k++) begin
      if (grant[k]) owner_idx = pw'(k);
    end
  end

  assign owner_inc = (owner_idx == pw'(nm - 1)) ? '0 : owner_idx + 1'b1;
  assign owner_cyc = |(grant & wbm_cyc_i);
  // While owned the search starts just past the owner, so a handover costs no idle cycle.
  assign pick_ptr  = (state == OWNED) ? owner_inc : ptr;

  rr_pick #(.nm(nm), .pw(pw)) u_pick (
    .req (wbm_cyc_i),
    .ptr (pick_ptr),
    .gnt (pick)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|wbm_cyc_i) begin
            grant <= pick;
            state <= OWNED;
          end
        end
        OWNED: begin
          if (!owner_cyc) begin
            grant <= pick;
            ptr   <= owner_inc;
            state <= (|pick) ? OWNED : IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    for (int k = 0; k < nm; k++) begin
      if (grant[k]) begin
        wbs_adr_o = wbm_adr_i[k*aw +: aw];
        wbs_dat_o = wbm_dat_i[k*dw +: dw];
        wbs_sel_o = wbm_sel_i[k*sw +: sw];
        wbs_cti_o = wbm_cti_i[k*3 +: 3];
        wbs_bte_o = wbm_bte_i[k*2 +: 2];
        wbs_cyc_o = wbm_cyc_i[k] & ~wd_block;
        wbs_stb_o = wbm_stb_i[k] & ~wd_block;
        wbs_we_o  = wbm_we_i[k];
      end
    end
  end

  assign wbm_dat_o = {nm{wbs_dat_i}};
  assign wbm_ack_o = grant & {nm{wbs_ack_i}};
  assign wbm_err_o = grant & {nm{wbs_err_i | wd_fire}};
  assign wbm_rty_o = grant & {nm{wbs_rty_i}};
  assign grant_o   = grant;

`ifdef RAM_WB_ARB_WATCHDOG_EN
  localparam int ww = $clog2(wd_cycles) + 1;

  logic [ww-1:0] wd_cnt;
  logic          wd_term;
  logic          grant_change;

  assign wd_term      = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign grant_change = (state == IDLE) ? (|wbm_cyc_i) : !owner_cyc;
  // Fires in the last stalled cycle; the count reaches wd_cycles on that edge.
  assign wd_fire      = wbs_stb_o && !wd_term && (wd_cnt == ww'(wd_cycles - 1));

  // The block holds the slave port quiet until the owner releases the bus.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wd_cnt   <= '0;
      wd_block <= 1'b0;
    end else begin
      if (grant_change || !wbs_stb_o || wd_term) wd_cnt <= '0;
      else                                       wd_cnt <= wd_cnt + 1'b1;
      if (grant_change)  wd_block <= 1'b0;
      else if (wd_fire)  wd_block <= 1'b1;
    end
  end
`else
  assign wd_fire  = 1'b0;
  assign wd_block = 1'b0;
`endif

endmodule

// File: tb/tb_ram_wb_arb.sv
// Directed bench for ram_wb_arb: a 3-master instance plus a 5-master 64-bit instance.
module tb_ram_wb_arb;

  import ram_wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [95:0]  m_adr, m_dat, m_dat_o;
  logic [11:0]  m_sel;
  logic [8:0]   m_cti;
  logic [5:0]   m_bte;
  logic [2:0]   m_cyc, m_stb, m_we, m_ack, m_err, m_rty, grant;
  logic [31:0]  s_adr, s_dat_o, s_dat_i;
  logic [3:0]   s_sel;
  logic [2:0]   s_cti;
  logic [1:0]   s_bte;
  logic         s_cyc, s_stb, s_we, s_ack, s_err, s_rty;

  logic [159:0] p_adr;
  logic [319:0] p_dat, p_dat_o;
  logic [39:0]  p_sel;
  logic [14:0]  p_cti;
  logic [9:0]   p_bte;
  logic [4:0]   p_cyc, p_stb, p_we, p_ack, p_err, p_rty, p_grant;
  logic [31:0]  ps_adr;
  logic [63:0]  ps_dat_o, ps_dat_i;
  logic [7:0]   ps_sel;
  logic [2:0]   ps_cti;
  logic [1:0]   ps_bte;
  logic         ps_cyc, ps_stb, ps_we, ps_ack, ps_err, ps_rty;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_wb_arb #(.nm(3), .dw(32), .aw(32), .wd_cycles(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_cti_i(m_cti),
    .wbm_bte_i(m_bte), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we),
    .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_cti_o(s_cti),
    .wbs_bte_o(s_bte), .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_we_o(s_we),
    .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant)
  );

  ram_wb_arb #(.nm(5), .dw(64), .aw(32), .wd_cycles(8)) dut5 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(p_adr), .wbm_dat_i(p_dat), .wbm_sel_i(p_sel), .wbm_cti_i(p_cti),
    .wbm_bte_i(p_bte), .wbm_cyc_i(p_cyc), .wbm_stb_i(p_stb), .wbm_we_i(p_we),
    .wbm_dat_o(p_dat_o), .wbm_ack_o(p_ack), .wbm_err_o(p_err), .wbm_rty_o(p_rty),
    .wbs_adr_o(ps_adr), .wbs_dat_o(ps_dat_o), .wbs_sel_o(ps_sel), .wbs_cti_o(ps_cti),
    .wbs_bte_o(ps_bte), .wbs_cyc_o(ps_cyc), .wbs_stb_o(ps_stb), .wbs_we_o(ps_we),
    .wbs_dat_i(ps_dat_i), .wbs_ack_i(ps_ack), .wbs_err_i(ps_err), .wbs_rty_i(ps_rty),
    .grant_o(p_grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0; m_bte = '0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    p_adr = '0; p_dat = '0; p_sel = '0; p_cti = '0; p_bte = '0;
    p_cyc = '0; p_stb = '0; p_we = '0;
    ps_dat_i = '0; ps_ack = 1'b0; ps_err = 1'b0; ps_rty = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    s_dat_i = 32'hCAFEF00D;
    s_ack = 1'b1;
    #12;
    rst = 1'b0;
    tick();
    total++; if (grant !== 3'b000) begin bad++; $display("[TB] FAIL reset_grant: got %b want %b", grant, 3'b000); end
    total++; if (s_cyc !== 1'b0) begin bad++; $display("[TB] FAIL reset_cyc: got %b want 0", s_cyc); end
    total++; if (s_stb !== 1'b0) begin bad++; $display("[TB] FAIL reset_stb: got %b want 0", s_stb); end
    total++; if (m_ack !== 3'b000) begin bad++; $display("[TB] FAIL reset_ack_gated: got %b want 000", m_ack); end
    total++; if (m_dat_o !== {3{32'hCAFEF00D}}) begin bad++; $display("[TB] FAIL reset_dat_fanout: got %h want %h", m_dat_o, {3{32'hCAFEF00D}}); end
    s_ack = 1'b0;
    m_adr[63:32] = 32'h80;
    m_cti[5:3] = CTI_INCR;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    tick();
    total++; if (grant !== 3'b010) begin bad++; $display("[TB] FAIL midburst_grant: got %b want 010", grant); end
    total++; if (s_cyc !== 1'b1) begin bad++; $display("[TB] FAIL midburst_cyc: got %b want 1", s_cyc); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (s_cyc !== 1'b0) begin bad++; $display("[TB] FAIL async_rst_cyc: got %b want 0", s_cyc); end
    total++; if (grant !== 3'b000) begin bad++; $display("[TB] FAIL async_rst_grant: got %b want 000", grant); end
    clear_inputs();
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_master();
    m_adr[95:64] = 32'h10;
    m_cyc[2] = 1'b1;
    m_stb[2] = 1'b1;
    #1;
    total++; if (grant !== 3'b000) begin bad++; $display("[TB] FAIL single_pre_grant: got %b want 000", grant); end
    tick();
    total++; if (grant !== 3'b100) begin bad++; $display("[TB] FAIL single_grant: got %b want 100", grant); end
    total++; if (s_adr !== 32'h10) begin bad++; $display("[TB] FAIL single_adr: got %h want %h", s_adr, 32'h10); end
    total++; if (s_cyc !== 1'b1 || s_we !== 1'b0) begin bad++; $display("[TB] FAIL single_cyc_we: got %b%b want 10", s_cyc, s_we); end
    s_ack = 1'b1;
    s_dat_i = 32'h12345678;
    #1;
    total++; if (m_ack !== 3'b100) begin bad++; $display("[TB] FAIL single_ack: got %b want 100", m_ack); end
    total++; if (m_dat_o[95:64] !== 32'h12345678) begin bad++; $display("[TB] FAIL single_rdata: got %h want 12345678", m_dat_o[95:64]); end
    tick();
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    #1;
    total++; if (m_ack !== 3'b000) begin bad++; $display("[TB] FAIL single_ack_clear: got %b want 000", m_ack); end
    tick();
    total++; if (grant !== 3'b000) begin bad++; $display("[TB] FAIL single_release: got %b want 000", grant); end
  endtask

  task automatic test_rotation();
    int seq [4] = '{0, 1, 2, 0};
    logic [2:0]  exp_g;
    logic [31:0] exp_a;
    do_reset();
    m_adr = {32'h3000, 32'h2000, 32'h1000};
    m_cyc = 3'b111;
    m_stb = 3'b111;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_g = 3'b001 << seq[i];
      exp_a = 32'h1000 * (seq[i] + 1);
      total++; if (grant !== exp_g) begin bad++; $display("[TB] FAIL rot_grant[%0d]: got %b want %b", i, grant, exp_g); end
      total++; if (s_adr !== exp_a) begin bad++; $display("[TB] FAIL rot_adr[%0d]: got %h want %h", i, s_adr, exp_a); end
      s_ack = 1'b1;
      #1;
      total++; if (m_ack !== exp_g) begin bad++; $display("[TB] FAIL rot_ack[%0d]: got %b want %b", i, m_ack, exp_g); end
      tick();
      m_cyc[seq[i]] = 1'b0;
      m_stb[seq[i]] = 1'b0;
      s_ack = 1'b0;
      #1;
      total++; if (grant !== exp_g) begin bad++; $display("[TB] FAIL rot_hold[%0d]: got %b want %b", i, grant, exp_g); end
      tick();
      m_cyc[seq[i]] = 1'b1;
      m_stb[seq[i]] = 1'b1;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_burst();
    int ack_cnt = 0;
    logic [2:0]  exp_cti;
    logic [31:0] exp_a;
    do_reset();
    m_adr[31:0] = 32'h100;
    m_cti[2:0] = CTI_INCR;
    m_adr[63:32] = 32'h200;
    m_cyc = 3'b011;
    m_stb = 3'b011;
    tick();
    total++; if (grant !== 3'b001) begin bad++; $display("[TB] FAIL burst_grant: got %b want 001", grant); end
    for (int b = 0; b < 4; b++) begin
      if (b == 3) m_cti[2:0] = CTI_EOB;
      if (b == 2) begin
        m_stb[0] = 1'b0;
        #1;
        total++; if (grant !== 3'b001 || s_cyc !== 1'b1 || s_stb !== 1'b0) begin bad++; $display("[TB] FAIL wait_state: got g=%b cyc=%b stb=%b want 001 1 0", grant, s_cyc, s_stb); end
        tick();
        m_stb[0] = 1'b1;
      end
      exp_cti = (b == 3) ? CTI_EOB : CTI_INCR;
      exp_a = 32'h100 + 32'(4 * b);
      s_ack = 1'b1;
      #1;
      total++; if (s_adr !== exp_a) begin bad++; $display("[TB] FAIL burst_adr[%0d]: got %h want %h", b, s_adr, exp_a); end
      total++; if (s_cti !== exp_cti) begin bad++; $display("[TB] FAIL burst_cti[%0d]: got %b want %b", b, s_cti, exp_cti); end
      total++; if (m_ack !== 3'b001) begin bad++; $display("[TB] FAIL burst_ack[%0d]: got %b want 001", b, m_ack); end
      if (m_ack[0] === 1'b1) ack_cnt++;
      tick();
      m_adr[31:0] = m_adr[31:0] + 32'd4;
      s_ack = 1'b0;
    end
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    #1;
    total++; if (ack_cnt != 4) begin bad++; $display("[TB] FAIL burst_ack_count: got %0d want 4", ack_cnt); end
    total++; if (grant !== 3'b001) begin bad++; $display("[TB] FAIL burst_no_split: got %b want 001", grant); end
    tick();
    total++; if (grant !== 3'b010) begin bad++; $display("[TB] FAIL burst_handover: got %b want 010", grant); end
    total++; if (s_adr !== 32'h200 || s_cyc !== 1'b1) begin bad++; $display("[TB] FAIL burst_next_req: got adr=%h cyc=%b want 200 1", s_adr, s_cyc); end
    clear_inputs();
    tick();
  endtask

  task automatic test_wide();
    p_adr[159:128] = 32'h40;
    p_dat[319:256] = 64'h1122334455667788;
    p_dat[127:64]  = 64'hDEADBEEFDEADBEEF;
    p_sel[39:32]   = 8'hF0;
    p_cyc[4] = 1'b1;
    p_stb[4] = 1'b1;
    p_we[4]  = 1'b1;
    tick();
    total++; if (p_grant !== 5'b10000) begin bad++; $display("[TB] FAIL wide_grant: got %b want 10000", p_grant); end
    total++; if (ps_sel !== 8'hF0) begin bad++; $display("[TB] FAIL wide_sel: got %h want f0", ps_sel); end
    total++; if (ps_dat_o !== 64'h1122334455667788) begin bad++; $display("[TB] FAIL wide_wdata: got %h want 1122334455667788", ps_dat_o); end
    total++; if (ps_adr !== 32'h40 || ps_we !== 1'b1) begin bad++; $display("[TB] FAIL wide_adr_we: got %h %b want 40 1", ps_adr, ps_we); end
    ps_ack = 1'b1;
    #1;
    total++; if (p_ack !== 5'b10000) begin bad++; $display("[TB] FAIL wide_ack: got %b want 10000", p_ack); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    m_cyc = 3'b011;
    m_stb = 3'b011;
    tick();
    total++; if (grant !== 3'b001) begin bad++; $display("[TB] FAIL stall_grant: got %b want 001", grant); end
`ifdef RAM_WB_ARB_WATCHDOG_EN
    for (int c = 1; c <= 8; c++) begin
      total++;
      if (m_err !== ((c == 8) ? 3'b001 : 3'b000)) begin
        bad++; $display("[TB] FAIL wd_err_cycle%0d: got %b want %b", c, m_err, (c == 8) ? 3'b001 : 3'b000);
      end
      tick();
    end
    total++; if (s_stb !== 1'b0 || s_cyc !== 1'b0) begin bad++; $display("[TB] FAIL wd_force_low: got cyc=%b stb=%b want 0 0", s_cyc, s_stb); end
    total++; if (m_err !== 3'b000) begin bad++; $display("[TB] FAIL wd_err_single: got %b want 000", m_err); end
    repeat (3) tick();
    total++; if (s_stb !== 1'b0 || grant !== 3'b001) begin bad++; $display("[TB] FAIL wd_hold_low: got stb=%b g=%b want 0 001", s_stb, grant); end
`else
    repeat (20) tick();
    total++; if (s_stb !== 1'b1 || grant !== 3'b001) begin bad++; $display("[TB] FAIL stall_hold: got stb=%b g=%b want 1 001", s_stb, grant); end
    total++; if (m_err !== 3'b000) begin bad++; $display("[TB] FAIL stall_no_err: got %b want 000", m_err); end
`endif
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    tick();
    total++; if (grant !== 3'b010 || s_stb !== 1'b1) begin bad++; $display("[TB] FAIL stall_release: got g=%b stb=%b want 010 1", grant, s_stb); end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_master();
    test_rotation();
    test_burst();
    test_wide();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
